// File: rtl/rsa_encrypt.sv
// RSA encryption engine: c = m^e mod n by left-to-right square-and-multiply
// built on a bit-serial interleaved modular multiplier (one operand bit per cycle).
module rsa_encrypt #(
  parameter int unsigned WIDTH      = 8,
  parameter bit          CONST_TIME = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [WIDTH-1:0]     m,
  input  logic [2*WIDTH-1:0]   e,
  input  logic [2*WIDTH-1:0]   n,
  output logic [2*WIDTH-1:0]   c_encrypted,
  output logic                 finish,
  output logic                 err,
  output logic                 busy
);

  localparam int unsigned E  = 2 * WIDTH;
  localparam int unsigned PW = E + 2;
  localparam int unsigned IW = $clog2(E);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_CHECK = 3'd1;
  localparam logic [2:0] S_SQR   = 3'd2;
  localparam logic [2:0] S_MUL   = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  logic [2:0]    state_q, state_d;
  logic [E-1:0]  m_q, m_d;
  logic [E-1:0]  e_q, e_d;
  logic [E-1:0]  n_q, n_d;
  logic [E-1:0]  r_q, r_d;
  logic [PW-1:0] p_q, p_d;
  logic [IW-1:0] i_q, i_d;
  logic [IW-1:0] j_q, j_d;
  logic [E-1:0]  c_q, c_d;
  logic          finish_q, finish_d;
  logic          err_q, err_d;
  logic          busy_q, busy_d;

  logic [E-1:0]  mul_b;
  logic [PW-1:0] n_ext, p_add, p_sub1, p_red;
  logic [E-1:0]  mul_res;
  logic [E-1:0]  bit_val;

  // One multiplier step: P = 2P + a[j]*b, then at most two subtractions of n.
  // Multiplicand a is always R; b is R when squaring and m when multiplying.
  always_comb begin
    mul_b   = (state_q == S_MUL) ? m_q : r_q;
    n_ext   = PW'(n_q);
    p_add   = PW'({p_q, 1'b0}) + (r_q[j_q] ? PW'(mul_b) : '0);
    p_sub1  = (p_add >= n_ext) ? (p_add - n_ext) : p_add;
    p_red   = (p_sub1 >= n_ext) ? (p_sub1 - n_ext) : p_sub1;
    mul_res = E'(p_red);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      m_q      <= '0;
      e_q      <= '0;
      n_q      <= '0;
      r_q      <= '0;
      p_q      <= '0;
      i_q      <= '0;
      j_q      <= '0;
      c_q      <= '0;
      finish_q <= 1'b0;
      err_q    <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      m_q      <= m_d;
      e_q      <= e_d;
      n_q      <= n_d;
      r_q      <= r_d;
      p_q      <= p_d;
      i_q      <= i_d;
      j_q      <= j_d;
      c_q      <= c_d;
      finish_q <= finish_d;
      err_q    <= err_d;
      busy_q   <= busy_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    m_d      = m_q;
    e_d      = e_q;
    n_d      = n_q;
    r_d      = r_q;
    p_d      = p_q;
    i_d      = i_q;
    j_d      = j_q;
    c_d      = c_q;
    finish_d = 1'b0;
    err_d    = err_q;
    busy_d   = busy_q;
    bit_val  = r_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          m_d     = E'(m);
          e_d     = e;
          n_d     = n;
          err_d   = 1'b0;
          c_d     = '0;
          busy_d  = 1'b1;
          state_d = S_CHECK;
        end
      end

      S_CHECK: begin
        if ((n_q < E'(2)) || (m_q >= n_q)) begin
          err_d    = 1'b1;
          c_d      = '0;
          finish_d = 1'b1;
          state_d  = S_DONE;
        end else begin
          r_d     = E'(1);
          p_d     = '0;
          i_d     = IW'(E - 1);
          j_d     = IW'(E - 1);
          state_d = S_SQR;
        end
      end

      S_SQR, S_MUL: begin
        p_d = p_red;
        j_d = j_q - IW'(1);
        if (j_q == '0) begin
          p_d = '0;
          j_d = IW'(E - 1);
          if (state_q == S_SQR) begin
            bit_val = mul_res;
            r_d     = mul_res;
          end else begin
            // Constant-time path still multiplies for e[i]=0 but discards the product.
            bit_val = e_q[i_q] ? mul_res : r_q;
            r_d     = bit_val;
          end
          if ((state_q == S_SQR) && (CONST_TIME || e_q[i_q])) begin
            state_d = S_MUL;
          end else if (i_q == '0) begin
            c_d      = bit_val;
            finish_d = 1'b1;
            state_d  = S_DONE;
          end else begin
            i_d     = i_q - IW'(1);
            state_d = S_SQR;
          end
        end
      end

      S_DONE: begin
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  assign c_encrypted = c_q;
  assign finish      = finish_q;
  assign err         = err_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_rsa_encrypt.sv
// Scoreboard bench for rsa_encrypt: a constant-time and a variable-time instance,
// directed vectors with hand-computed ciphertexts and latencies.
`timescale 1ns/1ps
module tb_rsa_encrypt;

  localparam int unsigned WIDTH = 8;
  localparam int unsigned E     = 2 * WIDTH;

  logic             clk = 1'b0;
  logic             rst;
  logic             start1, start0;
  logic [WIDTH-1:0] m;
  logic [E-1:0]     e_in, n_in;
  logic [E-1:0]     c1, c0;
  logic             fin1, fin0, err1, err0, busy1, busy0;

  always #5 clk = ~clk;

  rsa_encrypt #(.WIDTH(WIDTH), .CONST_TIME(1'b1)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .m(m), .e(e_in), .n(n_in),
    .c_encrypted(c1), .finish(fin1), .err(err1), .busy(busy1)
  );

  rsa_encrypt #(.WIDTH(WIDTH), .CONST_TIME(1'b0)) dut0 (
    .clk(clk), .rst(rst), .start(start0), .m(m), .e(e_in), .n(n_in),
    .c_encrypted(c0), .finish(fin0), .err(err0), .busy(busy0)
  );

  typedef struct {
    logic [E-1:0] c;
    logic         er;
    int           lat;
    int           t0;
    int           id;
  } exp_t;

  exp_t q1[$];
  exp_t q0[$];
  exp_t x1, x0;
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_bad = 0;
  int   lows1 = 0, lows0 = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm, input int id, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s (vector %0d): got %0d, required %0d", nm, id, act, req);
    end
  endtask

  function automatic int exp_lat(input bit ct, input logic [E-1:0] ev, input bit er);
    if (er) return 1;
    return 1 + E * (E + (ct ? E : $countones(ev)));
  endfunction

  // Constant-time instance monitor.
  always @(negedge clk) begin
    if (rst) begin
      lows1 = 0;
    end else if (fin1) begin
      if (q1.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL ct1 unexpected finish: got finish=1 with c=%0d, required no finish", c1);
      end else begin
        x1 = q1.pop_front();
        check("ct1 c_encrypted", x1.id, 32'(c1), 32'(x1.c));
        check("ct1 err", x1.id, 32'(err1), 32'(x1.er));
        check("ct1 latency", x1.id, 32'(cyc - x1.t0), 32'(x1.lat));
        check("ct1 busy at finish", x1.id, 32'(busy1), 32'd1);
        check("ct1 busy gaps", x1.id, 32'(lows1), 32'd0);
        lows1 = 0;
      end
    end else if ((q1.size() != 0) && !busy1) begin
      lows1++;
    end
  end

  // Variable-time instance monitor.
  always @(negedge clk) begin
    if (rst) begin
      lows0 = 0;
    end else if (fin0) begin
      if (q0.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL ct0 unexpected finish: got finish=1 with c=%0d, required no finish", c0);
      end else begin
        x0 = q0.pop_front();
        check("ct0 c_encrypted", x0.id, 32'(c0), 32'(x0.c));
        check("ct0 err", x0.id, 32'(err0), 32'(x0.er));
        check("ct0 latency", x0.id, 32'(cyc - x0.t0), 32'(x0.lat));
        check("ct0 busy at finish", x0.id, 32'(busy0), 32'd1);
        check("ct0 busy gaps", x0.id, 32'(lows0), 32'd0);
        lows0 = 0;
      end
    end else if ((q0.size() != 0) && !busy0) begin
      lows0++;
    end
  end

  task automatic issue(input bit ct, input int id, input logic [WIDTH-1:0] mv,
                       input logic [E-1:0] ev, input logic [E-1:0] nv,
                       input logic [E-1:0] cx, input bit ex);
    exp_t x;
    @(negedge clk);
    m = mv; e_in = ev; n_in = nv;
    if (ct) start1 = 1'b1; else start0 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    start0 = 1'b0;
    x.c   = cx;
    x.er  = ex;
    x.lat = exp_lat(ct, ev, ex);
    x.t0  = cyc;
    x.id  = id;
    if (ct) q1.push_back(x); else q0.push_back(x);
  endtask

  task automatic wait_idle(input int budget);
    int k = 0;
    while (((q1.size() != 0) || (q0.size() != 0)) && (k < budget)) begin
      @(negedge clk);
      k++;
    end
    if ((q1.size() != 0) || (q0.size() != 0)) begin
      n_cmp++;
      n_bad++;
      $display("FAIL timeout: %0d results outstanding after %0d cycles, required 0",
               q1.size() + q0.size(), budget);
      q1.delete();
      q0.delete();
    end
    @(negedge clk);
    check("idle busy ct1", 0, 32'(busy1), 32'd0);
    check("idle busy ct0", 0, 32'(busy0), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global timeout: simulation still running, required completion");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; start1 = 1'b0; start0 = 1'b0;
    m = '0; e_in = '0; n_in = '0;
    repeat (3) @(negedge clk);
    check("reset c ct1", 0, 32'(c1), 32'd0);
    check("reset finish ct1", 0, 32'(fin1), 32'd0);
    check("reset err ct1", 0, 32'(err1), 32'd0);
    check("reset busy ct1", 0, 32'(busy1), 32'd0);
    check("reset c ct0", 0, 32'(c0), 32'd0);
    check("reset busy ct0", 0, 32'(busy0), 32'd0);
    rst = 1'b0;

    issue(1'b1, 1, 8'd65, 16'd17, 16'd3233, 16'd2790, 1'b0);     wait_idle(700);
    issue(1'b0, 2, 8'd65, 16'd17, 16'd3233, 16'd2790, 1'b0);     wait_idle(700);
    issue(1'b0, 3, 8'd2, 16'hFFFF, 16'd3233, 16'd438, 1'b0);     wait_idle(700);
    issue(1'b1, 4, 8'd2, 16'd10, 16'd1000, 16'd24, 1'b0);        wait_idle(700);
    issue(1'b0, 5, 8'd2, 16'd10, 16'd1000, 16'd24, 1'b0);        wait_idle(700);
    issue(1'b1, 6, 8'd0, 16'd5, 16'd77, 16'd0, 1'b0);            wait_idle(700);
    issue(1'b1, 7, 8'd7, 16'd0, 16'd77, 16'd1, 1'b0);            wait_idle(700);
    issue(1'b0, 8, 8'd7, 16'd0, 16'd77, 16'd1, 1'b0);            wait_idle(700);
    issue(1'b1, 9, 8'd255, 16'hFFFF, 16'hFFFF, 16'd49215, 1'b0); wait_idle(700);
    issue(1'b0, 10, 8'd255, 16'hFFFF, 16'hFFFF, 16'd49215, 1'b0); wait_idle(700);

    // Invalid operands, then err/c held after finish, then cleared by a valid request.
    issue(1'b1, 11, 8'd0, 16'd3, 16'd1, 16'd0, 1'b1);            wait_idle(20);
    repeat (3) @(negedge clk);
    check("err held ct1", 11, 32'(err1), 32'd1);
    check("c held ct1", 11, 32'(c1), 32'd0);
    issue(1'b1, 12, 8'd60, 16'd17, 16'd50, 16'd0, 1'b1);         wait_idle(20);
    issue(1'b1, 13, 8'd2, 16'd10, 16'd1000, 16'd24, 1'b0);       wait_idle(700);

    // Operands changed after latching and a second start while busy must be ignored.
    issue(1'b1, 14, 8'd65, 16'd17, 16'd3233, 16'd2790, 1'b0);
    m = 8'd2; e_in = 16'd3; n_in = 16'd1000;
    repeat (98) @(negedge clk);
    m = 8'd9; start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    wait_idle(700);
    repeat (20) @(negedge clk);

    // Asynchronous reset mid-operation abandons it without a finish.
    issue(1'b1, 15, 8'd65, 16'd17, 16'd3233, 16'd2790, 1'b0);
    repeat (198) @(negedge clk);
    #2;
    rst = 1'b1;
    q1.delete();
    #1;
    check("async reset busy", 15, 32'(busy1), 32'd0);
    check("async reset c", 15, 32'(c1), 32'd0);
    check("async reset finish", 15, 32'(fin1), 32'd0);
    check("async reset err", 15, 32'(err1), 32'd0);
    repeat (5) @(negedge clk);
    rst = 1'b0;
    repeat (400) @(negedge clk);
    issue(1'b1, 16, 8'd65, 16'd17, 16'd3233, 16'd2790, 1'b0);    wait_idle(700);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
